// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD constants for the seconds timer path
package timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} tstate_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one mod-10 up/down BCD digit with sync load and ripple carry/borrow
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       dn_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       cin_i,
  output logic [3:0] q_o,
  output logic       cout_o
);
  logic [3:0] q_q, q_d;
  assign cout_o = cin_i & (dn_i ? q_q == 4'd0 : q_q == BCD_MAX);
  // non-decimal preset nibbles saturate to 9 so the register never leaves BCD range
  always_comb
    q_d = ld_i ? (ld_val_i > BCD_MAX ? BCD_MAX : ld_val_i)
        : !(en_i && cin_i) ? q_q
        : dn_i ? (q_q == 4'd0 ? BCD_MAX : q_q - 4'd1)
        : (q_q == BCD_MAX ? 4'd0 : q_q + 4'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: button-driven run control for a prescaled NDIG-digit BCD up/down counter
module bcd_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int NDIG     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              dir_i,
  input  logic [4*NDIG-1:0] load_val_i,
  output logic [4*NDIG-1:0] bcd_o,
  output logic              tick_o,
  output logic              running_o,
  output logic              done_o,
  output logic [1:0]        state_o
);
  localparam int PW = $clog2(TICK_DIV);
  tstate_t state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic tick_q, tick_d;
  logic start_q, stop_q, clear_q, load_q;
  logic start_ev, stop_ev, clear_ev, load_ev, ld_ok;
  logic up_term, dn_term, up_last, dn_last, cur_term, nxt_term, wrap, step;
  logic [4*NDIG-1:0] bcd;
  logic [NDIG:0] c;
  assign start_ev = start_i & ~start_q;
  assign stop_ev  = stop_i & ~stop_q;
  assign clear_ev = clear_i & ~clear_q;
  assign load_ev  = load_i & ~load_q;
  assign ld_ok    = load_ev && state_q != RUN;
  assign wrap     = psc_q == PW'(TICK_DIV - 1);
  // *_last: the value one step short of terminal, so DONE lands on the same edge as the step
  always_comb begin
    up_term = 1'b1;
    dn_term = 1'b1;
    up_last = 1'b1;
    dn_last = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      up_term &= bcd[4*i +: 4] == BCD_MAX;
      dn_term &= bcd[4*i +: 4] == 4'd0;
      up_last &= bcd[4*i +: 4] == (i == 0 ? 4'd8 : BCD_MAX);
      dn_last &= bcd[4*i +: 4] == (i == 0 ? 4'd1 : 4'd0);
    end
  end
  assign cur_term = dir_i ? dn_term : up_term;
  assign nxt_term = dir_i ? dn_last : up_last;
  // a tick at a value already terminal for the new direction stops rather than wrapping
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    tick_d  = 1'b0;
    step    = 1'b0;
    if (clear_ev || ld_ok) begin
      state_d = IDLE;
      psc_d   = '0;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          state_d = start_ev ? (cur_term ? DONE : RUN) : state_q;
          psc_d   = start_ev && cur_term ? '0 : psc_q;
        end
        RUN:
          if (stop_ev) state_d = PAUSE;
          else begin
            psc_d   = wrap ? '0 : psc_q + PW'(1);
            step    = wrap && !cur_term;
            tick_d  = step;
            state_d = wrap && (cur_term || nxt_term) ? DONE : RUN;
          end
        default: psc_d = '0;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      psc_q   <= '0;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      tick_q  <= tick_d;
      start_q <= start_i;
      stop_q  <= stop_i;
      clear_q <= clear_i;
      load_q  <= load_i;
    end
  assign c[0] = 1'b1;
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit u_dig (
      .clk     (clk),
      .rst     (rst),
      .en_i    (step),
      .dn_i    (dir_i),
      .ld_i    (clear_ev | ld_ok),
      .ld_val_i(clear_ev ? 4'd0 : load_val_i[4*g +: 4]),
      .cin_i   (c[g]),
      .q_o     (bcd[4*g +: 4]),
      .cout_o  (c[g+1])
    );
  end
  assign bcd_o     = bcd;
  assign tick_o    = tick_q;
  assign running_o = state_q == RUN;
  assign done_o    = state_q == DONE;
  assign state_o   = state_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed table plus randomized run checked against an integer-valued model
module tb_bcd_timer_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 0, stop_i = 0, clear_i = 0, load_i = 0, dir_i = 0;
  logic [15:0] load_val_i = '0, bcd_o;
  logic tick_o, running_o, done_o;
  logic [1:0] state_o;
  int nvec = 0, nerr = 0;
  bcd_timer_ctrl #(.TICK_DIV(4), .NDIG(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .load_i(load_i), .dir_i(dir_i), .load_val_i(load_val_i), .bcd_o(bcd_o),
    .tick_o(tick_o), .running_o(running_o), .done_o(done_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  int m_val, m_st, m_ph;
  logic m_tick, ps, pp, pc, pl;
  task automatic model_reset();
    m_val = 0; m_st = 0; m_ph = 0; m_tick = 0;
    ps = 0; pp = 0; pc = 0; pl = 0;
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction
  function automatic int sat_val(input logic [15:0] lv);
    int v = 0, p = 1, d;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      v += (d > 9 ? 9 : d) * p;
      p *= 10;
    end
    return v;
  endfunction
  function automatic bit term(input int v, input logic d);
    return d ? v == 0 : v == 9999;
  endfunction
  task automatic model_step(input logic s, p, c, l, d, input logic [15:0] lv);
    logic se, pe, ce, le;
    se = s & ~ps; pe = p & ~pp; ce = c & ~pc; le = l & ~pl;
    ps = s; pp = p; pc = c; pl = l;
    m_tick = 0;
    if (ce) begin m_val = 0; m_st = 0; m_ph = 0; end
    else if (le && m_st != 1) begin m_val = sat_val(lv); m_st = 0; m_ph = 0; end
    else if (m_st == 0 || m_st == 2) begin
      if (se && term(m_val, d)) begin m_st = 3; m_ph = 0; end
      else if (se) m_st = 1;
    end else if (m_st == 1) begin
      if (pe) m_st = 2;
      else if (m_ph == 3) begin
        m_ph = 0;
        if (term(m_val, d)) m_st = 3;
        else begin
          m_val = d ? m_val - 1 : m_val + 1;
          m_tick = 1;
          if (term(m_val, d)) m_st = 3;
        end
      end else m_ph++;
    end else m_ph = 0;
  endtask
  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [20:0] dut_out();
    return {bcd_o, tick_o, running_o, done_o, state_o};
  endfunction
  function automatic logic [20:0] model_out();
    return {to_bcd(m_val), m_tick, m_st == 1, m_st == 3, 2'(m_st)};
  endfunction
  int ncyc = 0;
  task automatic cyc(input logic s, p, c, l, d, input logic [15:0] lv);
    start_i = s; stop_i = p; clear_i = c; load_i = l; dir_i = d; load_val_i = lv;
    @(posedge clk);
    model_step(s, p, c, l, d, lv);
    #1;
    ncyc++;
    check($sformatf("model_cyc%0d", ncyc), dut_out(), model_out());
  endtask
  typedef struct {
    logic s, p, c, l, d;
    logic [15:0] lv;
    int n;
    logic [15:0] eb;
    logic [1:0] es;
    logic et;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(input logic s, p, c, l, d, input logic [15:0] lv, input int n,
                              input logic [15:0] eb, input logic [1:0] es, input logic et);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.l = l; v.d = d; v.lv = lv; v.n = n;
    v.eb = eb; v.es = es; v.et = et;
    tbl.push_back(v);
  endfunction
  initial begin
    //  s  p  c  l  d  load_val  n  exp_bcd  st  tick
    add(1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 3, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0001, 1, 1);
    add(0, 0, 0, 0, 0, 16'h0000, 36, 16'h0010, 1, 1);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 1, 0);
    add(0, 1, 0, 0, 0, 16'h0000, 1, 16'h0010, 2, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 5, 16'h0010, 2, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 2, 16'h0010, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0011, 1, 1);
    add(0, 0, 0, 1, 0, 16'h5555, 1, 16'h0011, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 3, 16'h0012, 1, 1);
    add(0, 1, 0, 0, 0, 16'h0000, 1, 16'h0012, 2, 0);
    add(0, 0, 0, 1, 0, 16'hA3F5, 1, 16'h9395, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h9395, 0, 0);
    add(0, 0, 0, 1, 0, 16'h9997, 1, 16'h9997, 0, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 1, 16'h9997, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 4, 16'h9998, 1, 1);
    add(0, 0, 0, 0, 0, 16'h0000, 4, 16'h9999, 3, 1);
    add(0, 0, 0, 0, 0, 16'h0000, 8, 16'h9999, 3, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 1, 16'h9999, 3, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h9999, 3, 0);
    add(0, 0, 0, 1, 1, 16'h0002, 1, 16'h0002, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 1, 16'h0002, 1, 0);
    add(0, 0, 0, 0, 1, 16'h0000, 4, 16'h0001, 1, 1);
    add(0, 0, 0, 0, 1, 16'h0000, 4, 16'h0000, 3, 1);
    add(0, 0, 0, 1, 1, 16'h0000, 1, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 3, 0);
    add(0, 0, 0, 0, 1, 16'h0000, 4, 16'h0000, 3, 0);
    add(0, 0, 0, 1, 0, 16'h1234, 1, 16'h1234, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h1234, 0, 0);
    add(0, 0, 1, 1, 0, 16'h5678, 1, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 3, 16'h0000, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 2, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 2, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0001, 1, 1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("reset", dut_out(), 21'd0);
    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++)
        cyc(tbl[k].s, tbl[k].p, tbl[k].c, tbl[k].l, tbl[k].d, tbl[k].lv);
      check($sformatf("tbl%0d", k), {bcd_o, state_o, tick_o}, {tbl[k].eb, tbl[k].es, tbl[k].et});
    end
    cyc(0, 0, 0, 0, 0, 16'h0000);
    #2 rst = 1'b1;
    #1 check("rst_mid_run", dut_out(), 21'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    begin
      logic d = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) d = ~d;
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, d, 16'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
